div_iter: RTL

Multi-cycle iterative 32-bit divider for the EX stage of the five-stage MIPS pipeline. It executes DIV/DIVU, produces {HI = remainder, LO = quotient}, and drives `div_stallE` into the hazard unit, which holds F/D/E while a division is in flight. One quotient bit is resolved per cycle, using radix-2 restoring division on operand magnitudes with sign correction at the end.

---
 rtl/div_iter_if.sv | 39 +++
 rtl/div_iter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/div_iter_if.sv
// Handshake and result bundle between the EX stage and the iterative divider.
// The slave modport is the divider side; the master modport is the pipeline side.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             cancel;
    logic             div_stallE;
    logic             div_validE;
    logic [WIDTH-1:0] hiE;
    logic [WIDTH-1:0] loE;

    modport slave (
        input  startE,
        input  signedE,
        input  srcaE,
        input  srcbE,
        input  cancel,
        output div_stallE,
        output div_validE,
        output hiE,
        output loE
    );

    modport master (
        output startE,
        output signedE,
        output srcaE,
        output srcbE,
        output cancel,
        input  div_stallE,
        input  div_validE,
        input  hiE,
        input  loE
    );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU in EX: one quotient bit per cycle on operand
// magnitudes, sign fix-up on the final iteration, HI = remainder and LO = quotient.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_iter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [5:0] LAST_COUNT = 6'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_stateNext;
    logic [5:0]       r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_absB;
    logic [WIDTH-1:0] r_dividend;
    logic             r_negQ;
    logic             r_negR;
    logic             r_divZero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_isIdle;
    logic             w_isBusy;
    logic             w_accept;
    logic             w_lastIter;
    logic             w_finish;
    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_trial;
    logic             w_trialOk;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;
    logic [WIDTH-1:0] w_hiFinal;
    logic [WIDTH-1:0] w_loFinal;

    assign w_isIdle   = (r_state == S_IDLE);
    assign w_isBusy   = (r_state == S_BUSY);
    assign w_accept   = w_isIdle & bus.startE & ~bus.cancel;
    assign w_lastIter = (r_count == LAST_COUNT);
    assign w_finish   = w_isBusy & w_lastIter & ~bus.cancel;

    assign w_aNeg = bus.signedE & bus.srcaE[WIDTH-1];
    assign w_bNeg = bus.signedE & bus.srcbE[WIDTH-1];
    assign w_absA = w_aNeg ? -bus.srcaE : bus.srcaE;
    assign w_absB = w_bNeg ? -bus.srcbE : bus.srcbE;

    // The remainder stays below |b|, so a non-negative trial always fits back in WIDTH bits.
    assign w_remShift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_remShift - {1'b0, r_absB};
    assign w_trialOk  = ~w_trial[WIDTH];
    assign w_remNext  = w_trialOk ? w_trial[WIDTH-1:0] : w_remShift[WIDTH-1:0];
    assign w_quoNext  = {r_quo[WIDTH-2:0], w_trialOk};

    // Divide-by-zero bypasses sign correction and reports the raw dividend in HI.
    assign w_hiFinal = r_divZero ? r_dividend
                     : (r_negR ? -w_remNext : w_remNext);
    assign w_loFinal = r_divZero ? {WIDTH{1'b1}}
                     : (r_negQ ? -w_quoNext : w_quoNext);

    always_comb begin
        w_stateNext = S_IDLE;
        case (r_state)
            S_IDLE:  w_stateNext = w_accept ? S_BUSY : S_IDLE;
            S_BUSY:  w_stateNext = w_lastIter ? S_DONE : S_BUSY;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
        if (bus.cancel) begin
            w_stateNext = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_absB     <= '0;
            r_dividend <= '0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_divZero  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_count    <= '0;
                r_rem      <= '0;
                r_quo      <= w_absA;
                r_absB     <= w_absB;
                r_dividend <= bus.srcaE;
                r_negQ     <= w_aNeg ^ w_bNeg;
                r_negR     <= w_aNeg;
                r_divZero  <= (bus.srcbE == '0);
            end else if (w_isBusy && !bus.cancel) begin
                r_count <= r_count + 6'd1;
                r_rem   <= w_remNext;
                r_quo   <= w_quoNext;
            end
        end
    end

    // HI/LO only change on a completed division; a cancel leaves the previous result intact.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_finish) begin
            r_hi <= w_hiFinal;
            r_lo <= w_loFinal;
        end
    end

    assign bus.div_stallE = w_accept | w_isBusy;
    assign bus.div_validE = (r_state == S_DONE);
    assign bus.hiE        = r_hi;
    assign bus.loE        = r_lo;
endmodule
